fifo_word_unpacker: RTL
=======================

Name: fifo_word_unpacker

Overview:
- Downstream consumer of the synchronous FIFO's read port; runs in the FIFO read-clock domain.
- Pops one DWIDTH-bit word at a time when the FIFO is not empty.
- Emits each word as DWIDTH/OWIDTH chunks, MSB chunk first, on a valid/ready stream toward the display/output logic.
- Flags the last chunk of each word and counts completed words.

Parameters:
- DWIDTH, 32, FIFO word width; must equal the FIFO's DWIDTH.
- OWIDTH, 8, output chunk width; DWIDTH % OWIDTH == 0 required; NCHUNK = DWIDTH/OWIDTH >= 1.
- CWIDTH, 16, width of the words_done counter.

Ports:
- clk  in  1  single clock, rising edge; the same clock as the FIFO read clock.
- reset  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DWIDTH  FIFO read data; valid the cycle after fifo_r_en is sampled high with fifo_empty low.
- fifo_r_en  out  1  FIFO read enable; single-cycle pulse.
- out_data  out  OWIDTH  current chunk.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the chunk when out_valid && out_ready.
- out_last  out  1  high with out_valid on the final chunk of a word.
- busy  out  1  high in any state other than IDLE.
- words_done  out  CWIDTH  count of fully transferred words; wraps modulo 2^CWIDTH.

Behaviour:
- Reset (reset low, async):
  - state=IDLE, shift register=0, chunk counter=0, words_done=0.
  - out_valid=0, out_last=0, out_data=0, fifo_r_en=0, busy=0.
- Release of reset is used synchronously: first state change is at the first clk edge with reset high.
- State IDLE:
  - fifo_r_en = !fifo_empty (combinational; only driven in IDLE).
  - If !fifo_empty at the clk edge -> FETCH.
- State FETCH (one cycle):
  - fifo_r_en=0.
  - FIFO registers dout on this same edge that leaves IDLE; the word is captured at the end of FETCH.
  - On edge: shift_reg <= fifo_dout; chunk counter <= 0 -> SEND.
- State SEND:
  - out_valid=1; out_data=shift_reg[DWIDTH-1 -: OWIDTH]; out_last=(chunk counter==NCHUNK-1).
  - On out_ready=1: shift_reg shifts left by OWIDTH (zero fill); counter +1.
  - If out_last, words_done +1 and -> IDLE.
  - On out_ready=0: hold; out_data and out_last stay stable; no shift.
- Timing and throughput:
  - No prefetch; a new fifo_r_en is never issued from SEND.
  - Best-case throughput: one word per NCHUNK+2 cycles.
  - Latency from fifo_empty falling to first out_valid: 2 cycles (IDLE edge, FETCH edge).
- NCHUNK=1: SEND lasts one handshake with out_last=1.
- Chunk counter width: max(1, $clog2(NCHUNK)); it never exceeds NCHUNK-1.
- words_done wraps from 2^CWIDTH-1 to 0 without a flag.
- fifo_empty changing during FETCH/SEND is ignored.
- Reset mid-operation: an in-flight word is discarded; the FIFO pointer has already advanced, so the word is lost. This is accepted behaviour.
- The FIFO's reset is active-high; the integrator drives it with !reset.

Test Plan:
- Reset: hold reset low 3 cycles with fifo_empty=0 -> fifo_r_en=0, out_valid=0, busy=0, words_done=0 throughout.
- Single word: FIFO holds 0xA1B2C3D4, out_ready=1 -> fifo_r_en high 1 cycle; out_data A1,B2,C3,D4 on 4 consecutive cycles starting 2 cycles later; out_last only on D4; words_done=1; back to IDLE.
- Backpressure: 0x11223344 with out_ready low for 3 cycles on chunk 0x22 -> 0x22 held stable with out_valid=1 and no shift; then 33,44; words_done=1.
- Back-to-back: FIFO holds 0x01020304 and 0x05060708, out_ready=1 -> 8 chunks 01..08 in order; exactly one 2-cycle gap between 04 and 05; exactly 2 fifo_r_en pulses; words_done=2.
- Empty FIFO: fifo_empty=1 for 20 cycles -> no fifo_r_en, out_valid=0, busy=0.
- Mid-word reset: assert reset during chunk 2 of 0xDEADBEEF -> out_valid=0 and words_done=0 immediately (async). After release, the next FIFO word 0xCAFEF00D is emitted from CA; no remnant of DEADBEEF appears.

Source files
------------

// File: rtl/fifo_word_unpacker.sv
// Pulls DWIDTH-bit words from a synchronous FIFO and streams them out as
// OWIDTH-bit chunks, MSB chunk first, over a valid/ready handshake.
module fifo_word_unpacker #(
  parameter int DWIDTH = 32,
  parameter int OWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_r_en,
  output logic [OWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CWIDTH-1:0] words_done
);

  localparam int NCHUNK = DWIDTH / OWIDTH;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DWIDTH-1:0] shift_reg;
  logic [CNTW-1:0]   chunk_cnt;
  logic              last_chunk;

  assign last_chunk = (chunk_cnt == CNTW'(NCHUNK - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_r_en = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        // Gated by reset so no pop can be requested while the block is held.
        fifo_r_en = reset & ~fifo_empty;
        if (!fifo_empty) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = shift_reg[DWIDTH-1 -: OWIDTH];
        out_last  = last_chunk;
        if (out_ready && last_chunk) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg  <= '0;
      chunk_cnt  <= '0;
      words_done <= '0;
    end else begin
      case (state)
        FETCH: begin
          shift_reg <= fifo_dout;
          chunk_cnt <= '0;
        end
        SEND: begin
          if (out_ready) begin
            shift_reg <= shift_reg << OWIDTH;
            if (last_chunk) begin
              // Counter returns to zero rather than reaching NCHUNK.
              chunk_cnt  <= '0;
              words_done <= words_done + CWIDTH'(1);
            end else begin
              chunk_cnt <= chunk_cnt + CNTW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
